// File: rtl/stream_capture_to_bram.sv
// Captures a programmable number of 32-bit AXI-stream beats into a block RAM
// through a registered native BRAM write port, started immediately or on orbit sync.
module stream_capture_to_bram #(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [31:0] data_stream_TDATA,
  input  logic        data_stream_TVALID,
  output logic        data_stream_TREADY,
  input  logic        fc_orbitSync,
  input  logic        cfg_arm,
  input  logic        cfg_abort,
  input  logic [1:0]  cfg_trigger_mode,
  input  logic [15:0] cfg_capture_len,
  output logic        bram_CLK,
  output logic        bram_RST,
  output logic        bram_EN,
  output logic [3:0]  bram_WE,
  output logic [31:0] bram_ADDR,
  output logic [31:0] bram_DIN,
  output logic [1:0]  status_state,
  output logic        status_done,
  output logic [15:0] status_words
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  // One extra bit so the count can reach MEM_DEPTH itself.
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [LEN_W-1:0]    arm_len;
  logic [LEN_W-1:0]    words_inc;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                en_q, en_d;
  logic                tready_q;
  logic                beat;
  logic                wr_go;

  assign beat      = data_stream_TVALID & tready_q;
  assign words_inc = words_q + LEN_W'(1);

  always_comb begin
    if (cfg_capture_len == 16'd0 || 32'(cfg_capture_len) > 32'(MEM_DEPTH))
      arm_len = LEN_W'(MEM_DEPTH);
    else
      arm_len = LEN_W'(cfg_capture_len);
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;
    din_d   = din_q;
    en_d    = 1'b0;
    wr_go   = 1'b0;

    if (cfg_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg_arm) begin
            len_d   = arm_len;
            words_d = '0;
            state_d = (cfg_trigger_mode == 2'd1) ? S_ARMED : S_CAPTURE;
          end
        end
        S_ARMED:   wr_go = beat & fc_orbitSync;
        S_CAPTURE: wr_go = beat;
        default:   state_d = S_IDLE;
      endcase
    end

    if (wr_go) begin
      en_d    = 1'b1;
      addr_d  = words_q[ADDR_W-1:0];
      din_d   = data_stream_TDATA;
      words_d = words_inc;
      state_d = (words_inc == len_q) ? S_DONE : S_CAPTURE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      words_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      en_q     <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      en_q     <= en_d;
      tready_q <= 1'b1;
    end
  end

  assign data_stream_TREADY = tready_q;
  assign bram_CLK           = clk;
  assign bram_RST           = ~aresetn;
  assign bram_EN            = en_q;
  assign bram_WE            = {4{en_q}};
  assign bram_ADDR          = 32'({addr_q, 2'b00});
  assign bram_DIN           = din_q;
  assign status_state       = state_q;
  assign status_done        = (state_q == S_DONE);
  assign status_words       = 16'(words_q);

endmodule

// File: tb/tb_stream_capture_to_bram.sv
// Directed bench for stream_capture_to_bram: table-driven capture scenarios plus
// hand-written abort, re-arm and mid-capture reset sequences.
module tb_stream_capture_to_bram;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        fc_sync;
  logic        cfg_arm;
  logic        cfg_abort;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic        bram_clk, bram_rst, bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_din;
  logic [1:0]  st_state;
  logic        st_done;
  logic [15:0] st_words;

  int checks   = 0;
  int failures = 0;
  int we_bad   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  stream_capture_to_bram #(.MEM_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .data_stream_TDATA  (tdata),
    .data_stream_TVALID (tvalid),
    .data_stream_TREADY (tready),
    .fc_orbitSync       (fc_sync),
    .cfg_arm            (cfg_arm),
    .cfg_abort          (cfg_abort),
    .cfg_trigger_mode   (cfg_mode),
    .cfg_capture_len    (cfg_len),
    .bram_CLK           (bram_clk),
    .bram_RST           (bram_rst),
    .bram_EN            (bram_en),
    .bram_WE            (bram_we),
    .bram_ADDR          (bram_addr),
    .bram_DIN           (bram_din),
    .status_state       (st_state),
    .status_done        (st_done),
    .status_words       (st_words)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (aresetn) begin
      if (bram_en) begin
        wr_addr.push_back(bram_addr);
        wr_data.push_back(bram_din);
        if (bram_we !== 4'hF) we_bad++;
      end else if (bram_we !== 4'h0) begin
        we_bad++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] len;
    bit          gap;
    int          sync_at;
    logic [31:0] base;
    int          exp_words;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] exp_q[$];
    bit          started;
    int          captured;
    int          len_eff;
    bit          done_seen;
    string       tag;
    tag = $sformatf("v%0d", idx);
    clear_log();
    cfg_mode  = v.mode;
    cfg_len   = v.len;
    cfg_arm   = 1'b1;
    tvalid    = 1'b1;
    tdata     = 32'hEE;
    fc_sync   = 1'b0;
    tick();
    cfg_arm = 1'b0;
    check({tag, "_arm_state"}, 32'(st_state), (v.mode == 2'd1) ? 32'd1 : 32'd2);
    check({tag, "_arm_words"}, 32'(st_words), 32'd0);

    started   = (v.mode != 2'd1);
    captured  = 0;
    len_eff   = (v.len == 16'd0 || int'(v.len) > DEPTH) ? DEPTH : int'(v.len);
    done_seen = 1'b0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      tvalid  = v.gap ? (c % 2 == 0) : 1'b1;
      tdata   = v.base + 32'(c);
      fc_sync = (c == v.sync_at) || (c == v.sync_at + 3);
      if (tvalid) begin
        if (!started && fc_sync) started = 1'b1;
        if (started && captured < len_eff) begin
          exp_q.push_back(tdata);
          captured++;
        end
      end
      tick();
      done_seen = st_done;
    end
    fc_sync = 1'b0;
    tvalid  = 1'b1;
    tick();
    tick();
    tvalid = 1'b0;
    tick();

    check({tag, "_done"},   32'(done_seen), 32'd1);
    check({tag, "_state"},  32'(st_state), 32'd3);
    check({tag, "_words"},  32'(st_words), 32'(v.exp_words));
    check({tag, "_nwrites"}, 32'(wr_data.size()), 32'(v.exp_words));
    if (wr_data.size() > 0) check({tag, "_first"}, wr_data[0], v.exp_first);
    for (int i = 0; i < wr_data.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_q[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn   = 1'b0;
    tdata     = '0;
    tvalid    = 1'b0;
    fc_sync   = 1'b0;
    cfg_arm   = 1'b0;
    cfg_abort = 1'b0;
    cfg_mode  = 2'd0;
    cfg_len   = 16'd0;

    vecs[0] = '{2'd0, 16'd4,   1'b0, -10, 32'hA0,  4,  32'hA0};
    vecs[1] = '{2'd1, 16'd3,   1'b0,  10, 32'h100, 3,  32'h10A};
    vecs[2] = '{2'd0, 16'd0,   1'b1, -10, 32'h400, 16, 32'h400};
    vecs[3] = '{2'd0, 16'd100, 1'b0, -10, 32'h500, 16, 32'h500};
    vecs[4] = '{2'd2, 16'd2,   1'b1, -10, 32'h600, 2,  32'h600};
    vecs[5] = '{2'd1, 16'd1,   1'b1,   5, 32'h700, 1,  32'h708};
    vecs[6] = '{2'd3, 16'd16,  1'b0, -10, 32'h800, 16, 32'h800};

    tick();
    tick();
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_en",     32'(bram_en), 32'd0);
    check("rst_we",     32'(bram_we), 32'd0);
    check("rst_addr",   bram_addr, 32'd0);
    check("rst_din",    bram_din, 32'd0);
    check("rst_state",  32'(st_state), 32'd0);
    check("rst_done",   32'(st_done), 32'd0);
    check("rst_words",  32'(st_words), 32'd0);
    check("rst_bramrst", 32'(bram_rst), 32'd1);
    aresetn = 1'b1;
    tick();
    check("post_rst_tready", 32'(tready), 32'd1);
    check("post_rst_bramrst", 32'(bram_rst), 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Abort at word 5 of a 10-word capture; the abort-cycle beat is dropped.
    clear_log();
    cfg_mode = 2'd0; cfg_len = 16'd10; cfg_arm = 1'b1; tvalid = 1'b0;
    tick();
    cfg_arm = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tvalid = 1'b1; tdata = 32'h200 + 32'(c);
      tick();
    end
    tdata = 32'h205; cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0; tvalid = 1'b0;
    tick();
    tick();
    check("abort_nwrites", 32'(wr_data.size()), 32'd5);
    if (wr_data.size() > 0) check("abort_last", wr_data[wr_data.size()-1], 32'h204);
    check("abort_state", 32'(st_state), 32'd0);
    check("abort_words", 32'(st_words), 32'd5);

    // Arm and abort together: abort wins.
    clear_log();
    cfg_arm = 1'b1; cfg_abort = 1'b1;
    tick();
    cfg_arm = 1'b0; cfg_abort = 1'b0; tvalid = 1'b1; tdata = 32'h2FF;
    tick();
    tvalid = 1'b0;
    tick();
    check("armabort_state", 32'(st_state), 32'd0);
    check("armabort_words", 32'(st_words), 32'd5);
    check("armabort_nwrites", 32'(wr_data.size()), 32'd0);

    // Arm during CAPTURE is ignored.
    clear_log();
    cfg_mode = 2'd0; cfg_len = 16'd6; cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tvalid = 1'b1; tdata = 32'h300 + 32'(c);
      if (c == 2) begin cfg_arm = 1'b1; cfg_mode = 2'd1; cfg_len = 16'd2; end
      tick();
      cfg_arm = 1'b0;
    end
    tvalid = 1'b0;
    tick();
    check("ignarm_nwrites", 32'(wr_data.size()), 32'd6);
    check("ignarm_done", 32'(st_done), 32'd1);
    check("ignarm_words", 32'(st_words), 32'd6);
    if (wr_data.size() == 6) begin
      check("ignarm_addr5", wr_addr[5], 32'd20);
      check("ignarm_data5", wr_data[5], 32'h305);
    end

    // Re-arm from DONE restarts at address 0.
    clear_log();
    cfg_mode = 2'd0; cfg_len = 16'd2; cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("rearm_state", 32'(st_state), 32'd2);
    check("rearm_words", 32'(st_words), 32'd0);
    check("rearm_done",  32'(st_done), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tvalid = 1'b1; tdata = 32'h900 + 32'(c);
      tick();
    end
    tvalid = 1'b0;
    tick();
    check("rearm_nwrites", 32'(wr_data.size()), 32'd2);
    if (wr_data.size() > 0) begin
      check("rearm_addr0", wr_addr[0], 32'd0);
      check("rearm_data0", wr_data[0], 32'h900);
    end
    check("rearm_fin_done", 32'(st_done), 32'd1);

    // Reset asserted mid-capture at word 2.
    clear_log();
    cfg_len = 16'd10; cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tvalid = 1'b1; tdata = 32'hB00 + 32'(c);
      tick();
    end
    tdata = 32'hB02;
    aresetn = 1'b0;
    #1;
    check("midrst_tready", 32'(tready), 32'd0);
    check("midrst_en",     32'(bram_en), 32'd0);
    check("midrst_we",     32'(bram_we), 32'd0);
    check("midrst_addr",   bram_addr, 32'd0);
    check("midrst_din",    bram_din, 32'd0);
    check("midrst_state",  32'(st_state), 32'd0);
    check("midrst_words",  32'(st_words), 32'd0);
    check("midrst_bramrst", 32'(bram_rst), 32'd1);
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    tick();
    check("relrst_tready", 32'(tready), 32'd1);
    check("relrst_state",  32'(st_state), 32'd0);
    check("relrst_words",  32'(st_words), 32'd0);
    check("relrst_en",     32'(bram_en), 32'd0);
    tvalid = 1'b0;
    tick();

    check("we_strobe_shape", 32'(we_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
